// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the chunked add/subtract unit.
package addsub_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int nchunk_f(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Chunk index width; never zero so a single-chunk build still has a legal register.
   function automatic int idx_w_f(input int width, input int chunk);
      int n;
      n = width / chunk;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple of full adders; also exposes the carry into
// its top bit so the caller can form signed overflow on the final chunk.
module addsub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [CHUNK:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < CHUNK; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout     = c[CHUNK];
   assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/addsub_chunked_seq.sv
// Multi-cycle WIDTH-bit add/subtract: one CHUNK-bit slice of the carry chain per
// clock, operands in and result/flags out over valid/ready handshakes.
module addsub_chunked_seq
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             m,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             v,
   output logic             z,
   output logic             busy
);

   localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
   localparam int KW     = idx_w_f(WIDTH, CHUNK);
   localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

   if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_chk
      $error("addsub_chunked_seq: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             c_q, c_d;
   logic             v_q, v_d;
   logic             z_q, z_d;

   logic [CHUNK-1:0] ch_sum;
   logic             ch_cout, ch_cmsb;

   // b_q already holds the one's complement for subtract; carry_q supplies the +1.
   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (a_q[int'(k_q)*CHUNK +: CHUNK]),
      .b        (b_q[int'(k_q)*CHUNK +: CHUNK]),
      .cin      (carry_q),
      .sum      (ch_sum),
      .cout     (ch_cout),
      .c_msb_in (ch_cmsb)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      k_d     = k_q;
      s_d     = s_q;
      c_d     = c_q;
      v_d     = v_q;
      z_d     = z_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = (m == OP_SUB) ? ~b : b;
               carry_d = (m != OP_ADD);
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[int'(k_q)*CHUNK +: CHUNK] = ch_sum;
            carry_d = ch_cout;
            k_d     = k_q + KW'(1);
            if (k_q == K_LAST) begin
               c_d     = ch_cout;
               v_d     = ch_cmsb ^ ch_cout;
               z_d     = (s_d == '0);
               k_d     = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
         s_q     <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         k_q     <= k_d;
         s_q     <= s_d;
         c_q     <= c_d;
         v_q     <= v_d;
         z_q     <= z_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign s         = s_q;
   assign c_out     = c_q;
   assign v         = v_q;
   assign z         = z_q;

endmodule

// File: tb/tb_addsub_chunked_seq.sv
// Bench for addsub_chunked_seq: three instances (CHUNK 4, 1, 16) share stimulus
// and are checked against an integer-arithmetic reference.
module tb_addsub_chunked_seq;

   localparam int W  = 16;
   localparam int NI = 3;

   logic         clk = 1'b0;
   logic         rst, in_valid, out_ready, m;
   logic [W-1:0] a, b;

   logic         in_ready_w [NI];
   logic         out_valid_w[NI];
   logic         c_w        [NI];
   logic         v_w        [NI];
   logic         z_w        [NI];
   logic         busy_w     [NI];
   logic [W-1:0] s_w        [NI];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   function automatic int chunk_of(input int g);
      return (g == 0) ? 4 : ((g == 1) ? 1 : 16);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int CH = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
      addsub_chunked_seq #(.WIDTH(W), .CHUNK(CH)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready_w[g]),
         .a         (a),
         .b         (b),
         .m         (m),
         .out_valid (out_valid_w[g]),
         .out_ready (out_ready),
         .s         (s_w[g]),
         .c_out     (c_w[g]),
         .v         (v_w[g]),
         .z         (z_w[g]),
         .busy      (busy_w[g])
      );
   end

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         m;
      logic [W-1:0] s;
      logic         c;
      logic         v;
      logic         z;
   } vec_t;

   vec_t tbl[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   // Reference: plain unsigned/signed integer arithmetic.
   task automatic model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic mi,
                        output logic [W-1:0] es, output logic ec, output logic ev, output logic ez);
      int ua, ub, sa, sb, ur, sr;
      ua = int'(ai);
      ub = int'(bi);
      sa = int'($signed(ai));
      sb = int'($signed(bi));
      if (!mi) begin
         ur = ua + ub;
         sr = sa + sb;
         ec = (ur > 65535);
      end else begin
         ur = ua - ub;
         sr = sa - sb;
         ec = (ua >= ub);
      end
      es = ur[W-1:0];
      ev = (sr > 32767) || (sr < -32768);
      ez = (es == '0);
   endtask

   task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic mi,
                         output logic [W-1:0] s0, output logic c0, output logic v0, output logic z0);
      bit           done[NI];
      int           ndone;
      logic [W-1:0] es;
      logic         ec, ev, ez;
      model(ai, bi, mi, es, ec, ev, ez);
      s0 = '0; c0 = 1'b0; v0 = 1'b0; z0 = 1'b0;
      ndone = 0;
      for (int g = 0; g < NI; g++) begin
         done[g] = 1'b0;
         chk($sformatf("pre_in_ready[ch%0d]", chunk_of(g)), 32'(in_ready_w[g]), 32'd1);
      end
      a = ai; b = bi; m = mi; in_valid = 1'b1; out_ready = 1'b1;
      step();
      // Scramble inputs after the accepting edge; results must not follow them.
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      m = 1'($urandom_range(0, 1));
      for (int cyc = 1; cyc <= 40 && ndone < NI; cyc++) begin
         step();
         for (int g = 0; g < NI; g++) begin
            if (!done[g] && out_valid_w[g]) begin
               done[g] = 1'b1;
               ndone++;
               chk($sformatf("latency[ch%0d]", chunk_of(g)), 32'(cyc), 32'(W / chunk_of(g)));
               chk($sformatf("s[ch%0d] %h%s%h", chunk_of(g), ai, mi ? "-" : "+", bi), 32'(s_w[g]), 32'(es));
               chk($sformatf("c_out[ch%0d] %h%s%h", chunk_of(g), ai, mi ? "-" : "+", bi), 32'(c_w[g]), 32'(ec));
               chk($sformatf("v[ch%0d] %h%s%h", chunk_of(g), ai, mi ? "-" : "+", bi), 32'(v_w[g]), 32'(ev));
               chk($sformatf("z[ch%0d] %h%s%h", chunk_of(g), ai, mi ? "-" : "+", bi), 32'(z_w[g]), 32'(ez));
               if (g == 0) begin
                  s0 = s_w[0]; c0 = c_w[0]; v0 = v_w[0]; z0 = z_w[0];
               end
            end
         end
      end
      for (int g = 0; g < NI; g++)
         if (!done[g]) chk($sformatf("timeout_out_valid[ch%0d]", chunk_of(g)), 32'(done[g]), 32'd1);
      step();
   endtask

   initial begin
      logic [W-1:0] rs;
      logic         rc, rv, rz;
      int           lat, seen;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; m = 1'b0; a = '0; b = '0;

      tbl[0] = '{16'd100,  16'd99,   1'b0, 16'd199,  1'b0, 1'b0, 1'b0};
      tbl[1] = '{16'd5,    16'd7,    1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
      tbl[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};

      step(); step();
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("rst_flags[ch%0d]", chunk_of(g)),
             32'({out_valid_w[g], in_ready_w[g], busy_w[g], c_w[g], v_w[g], z_w[g]}), 32'd0);
         chk($sformatf("rst_s[ch%0d]", chunk_of(g)), 32'(s_w[g]), 32'd0);
      end
      rst = 1'b0;
      step();
      for (int g = 0; g < NI; g++)
         chk($sformatf("in_ready_after_rst[ch%0d]", chunk_of(g)), 32'(in_ready_w[g]), 32'd1);

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].m, rs, rc, rv, rz);
         chk($sformatf("tbl%0d_s", i), 32'(rs), 32'(tbl[i].s));
         chk($sformatf("tbl%0d_c", i), 32'(rc), 32'(tbl[i].c));
         chk($sformatf("tbl%0d_v", i), 32'(rv), 32'(tbl[i].v));
         chk($sformatf("tbl%0d_z", i), 32'(rz), 32'(tbl[i].z));
      end

      // Backpressure: hold result in DONE, pulse in_valid, then release.
      a = 16'd3; b = 16'd4; m = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid_w[0] && lat < 20) begin
         step();
         lat++;
      end
      chk("bp_latency", 32'(lat), 32'd4);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         a = 16'hAAAA; b = 16'h5555; m = 1'b1;
         step();
         chk("bp_out_valid", 32'(out_valid_w[0]), 32'd1);
         chk("bp_s", 32'(s_w[0]), 32'd7);
         chk("bp_flags", 32'({c_w[0], v_w[0], z_w[0]}), 32'd0);
         chk("bp_in_ready", 32'(in_ready_w[0]), 32'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("bp_release_out_valid", 32'(out_valid_w[0]), 32'd0);
      chk("bp_release_in_ready", 32'(in_ready_w[0]), 32'd1);
      lat = 0;
      while (!(in_ready_w[0] && in_ready_w[1] && in_ready_w[2]) && lat < 40) begin
         step();
         lat++;
      end
      chk("bp_drain_timeout", 32'(lat < 40), 32'd1);

      // Reset mid-RUN after two chunks of the CHUNK=4 instance.
      a = 16'h1111; b = 16'h2222; m = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step();
      chk("midrun_busy", 32'(busy_w[0]), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrun_rst_flags", 32'({out_valid_w[0], in_ready_w[0], busy_w[0], c_w[0], v_w[0], z_w[0]}), 32'd0);
      chk("midrun_rst_s", 32'(s_w[0]), 32'd0);
      step();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         for (int g = 0; g < NI; g++) if (out_valid_w[g]) seen++;
      end
      chk("midrun_no_out_valid", 32'(seen), 32'd0);
      run_op(16'h0F0F, 16'h0101, 1'b1, rs, rc, rv, rz);
      chk("after_rst_s", 32'(rs), 32'h0E0E);
      chk("after_rst_c", 32'(rc), 32'd1);

      // Strided small-operand sweep, both modes, all three chunk sizes.
      for (int x = 0; x < 100; x += 7)
         for (int y = 0; y < 100; y += 7)
            for (int mm = 0; mm < 2; mm++)
               run_op(W'(x), W'(y), 1'(mm), rs, rc, rv, rz);
      run_op(16'd99, 16'd99, 1'b0, rs, rc, rv, rz);
      run_op(16'd0, 16'd99, 1'b1, rs, rc, rv, rz);

      for (int i = 0; i < 150; i++)
         run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), rs, rc, rv, rz);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
